// File: rtl/prewish_blinky_if.sv
// Mask-strobe bus between the mentor and prewish_blinky.
interface prewish_blinky_if;
  logic       STB_I;
  logic [7:0] DAT_I;
  logic       ACK_O;

  modport master (output STB_I, output DAT_I, input ACK_O);
  modport slave  (input STB_I, input DAT_I, output ACK_O);
endinterface

// File: rtl/prewish_blinky.sv
// LED blinker: latches 8-bit masks from a strobe bus and shifts them out MSB-first,
// one bit per prescaler period, repeating; new masks take effect only at a pass boundary.
module prewish_blinky #(
  parameter int unsigned BLINKY_CLK_BITS = 9
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  prewish_blinky_if.slave   bus,
  output logic              o_led,
  output logic              o_busy,
  output logic              o_pass
);

  localparam int unsigned PW = BLINKY_CLK_BITS;
  localparam int unsigned IW = 3;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]    state, state_nx;
  logic [7:0]    mask, mask_nx;
  logic [7:0]    pending, pending_nx;
  logic          pending_valid, pending_valid_nx;
  logic [IW-1:0] idx, idx_nx;
  logic [PW-1:0] presc, presc_nx;
  logic          led_nx, pass_nx;
  logic          stb_prev;
  logic          accept_c, tick_c, wrap_c;

  // Next-state and output decode
  always_comb begin
    state_nx         = state;
    mask_nx          = mask;
    pending_nx       = pending;
    pending_valid_nx = pending_valid;
    idx_nx           = idx;
    presc_nx         = presc;
    led_nx           = o_led;
    pass_nx          = 1'b0;
    accept_c         = bus.STB_I & ~stb_prev;
    tick_c           = (presc == {PW{1'b1}});
    wrap_c           = tick_c & (idx == IW'(0));

    if (state == ST_IDLE) begin
      led_nx   = 1'b0;
      presc_nx = '0;
      if (accept_c) begin
        mask_nx  = bus.DAT_I;
        idx_nx   = IW'(7);
        state_nx = ST_RUN;
        led_nx   = bus.DAT_I[7];
      end
    end else begin
      presc_nx = presc + PW'(1);
      if (wrap_c) begin
        idx_nx  = IW'(7);
        pass_nx = 1'b1;
        // Coincident strobe beats a queued mask, which is then dropped
        if (accept_c) begin
          mask_nx          = bus.DAT_I;
          pending_nx       = 8'h00;
          pending_valid_nx = 1'b0;
          led_nx           = bus.DAT_I[7];
        end else if (pending_valid) begin
          mask_nx          = pending;
          pending_valid_nx = 1'b0;
          led_nx           = pending[7];
        end else begin
          led_nx = mask[7];
        end
      end else begin
        if (tick_c) begin
          idx_nx = idx - IW'(1);
          led_nx = mask[idx - IW'(1)];
        end
        if (accept_c) begin
          pending_nx       = bus.DAT_I;
          pending_valid_nx = 1'b1;
        end
      end
    end
  end

  // State and output registers
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state         <= ST_IDLE;
      mask          <= 8'h00;
      pending       <= 8'h00;
      pending_valid <= 1'b0;
      idx           <= IW'(7);
      presc         <= '0;
      stb_prev      <= 1'b1;
      o_led         <= 1'b0;
      o_busy        <= 1'b0;
      o_pass        <= 1'b0;
      bus.ACK_O     <= 1'b0;
    end else begin
      state         <= state_nx;
      mask          <= mask_nx;
      pending       <= pending_nx;
      pending_valid <= pending_valid_nx;
      idx           <= idx_nx;
      presc         <= presc_nx;
      stb_prev      <= bus.STB_I;
      o_led         <= led_nx;
      o_busy        <= (state_nx == ST_RUN);
      o_pass        <= pass_nx;
      bus.ACK_O     <= accept_c;
    end
  end

endmodule

// File: tb/tb_prewish_blinky.sv
// Directed bench for prewish_blinky; expected masks are queued as strobes are driven
// and consumed at each pass boundary.
module tb_prewish_blinky;

  logic clk = 1'b0;
  logic rst;
  logic led, busy, pass;
  logic led9, busy9, pass9;

  always #5 clk = ~clk;

  prewish_blinky_if bus ();
  prewish_blinky_if bus9 ();

  prewish_blinky #(.BLINKY_CLK_BITS(2)) dut (
    .CLK_I (clk),
    .RST_I (rst),
    .bus   (bus),
    .o_led (led),
    .o_busy(busy),
    .o_pass(pass)
  );

  prewish_blinky #(.BLINKY_CLK_BITS(9)) dut9 (
    .CLK_I (clk),
    .RST_I (rst),
    .bus   (bus9),
    .o_led (led9),
    .o_busy(busy9),
    .o_pass(pass9)
  );

  int errors = 0;
  int checks = 0;
  int ph = 0;
  bit sb_on = 1'b0;
  logic [7:0] cur = 8'h00;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock; when tracking a pass, compare LED bit, pass pulse and busy
  task automatic cyc();
    @(posedge clk);
    #1;
    if (sb_on) begin
      ph = (ph + 1) % 32;
      if (ph == 0 && exp_q.size() > 0) cur = exp_q.pop_front();
      chk("led", 32'(led), 32'(cur[3'(7 - ph / 4)]));
      chk("pass", 32'(pass), 32'(ph == 0));
      chk("busy", 32'(busy), 32'd1);
    end
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic wait_ph(input int p);
    int n = 0;
    while (ph != p && n < 64) begin
      cyc();
      n++;
    end
    chk("wait_ph", 32'(ph), 32'(p));
  endtask

  // Strobe from IDLE: first LED bit one cycle after the edge
  task automatic start(input logic [7:0] d);
    sb_on = 1'b0;
    bus.STB_I = 1'b1;
    bus.DAT_I = d;
    @(posedge clk);
    #1;
    chk("start_ack", 32'(bus.ACK_O), 32'd1);
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_led", 32'(led), 32'(d[7]));
    chk("start_pass", 32'(pass), 32'd0);
    ph = 0;
    cur = d;
    exp_q.delete();
    sb_on = 1'b1;
    bus.STB_I = 1'b0;
    cyc();
    chk("start_ack_off", 32'(bus.ACK_O), 32'd0);
  endtask

  // Strobe while running: last accepted mask shows at the next pass
  task automatic strobe(input logic [7:0] d);
    bus.STB_I = 1'b1;
    bus.DAT_I = d;
    exp_q.delete();
    exp_q.push_back(d);
    cyc();
    chk("ack", 32'(bus.ACK_O), 32'd1);
    bus.STB_I = 1'b0;
    cyc();
    chk("ack_off", 32'(bus.ACK_O), 32'd0);
  endtask

  initial begin
    int acks;
    int led_bad;
    int pass_bad;
    int npass;

    rst = 1'b1;
    bus.STB_I = 1'b0;
    bus.DAT_I = 8'h00;
    bus9.STB_I = 1'b0;
    bus9.DAT_I = 8'h00;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack", 32'(bus.ACK_O), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_busy9", 32'(busy9), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic pattern over two full passes
    start(8'hA8);
    run(70);

    // Mid-pass change waits for the wrap
    wait_ph(12);
    strobe(8'hCA);
    run(70);

    // Long strobe accepted once
    wait_ph(4);
    bus.STB_I = 1'b1;
    bus.DAT_I = 8'hCA;
    exp_q.delete();
    exp_q.push_back(8'hCA);
    acks = 0;
    repeat (50) begin
      cyc();
      if (bus.ACK_O === 1'b1) acks++;
    end
    chk("long_strobe_acks", 32'(acks), 32'd1);
    bus.STB_I = 1'b0;

    // Two strobes in one pass: only the last is shown
    wait_ph(2);
    strobe(8'hF0);
    strobe(8'h0F);
    run(80);

    // Strobe coincident with the wrap beats a queued mask
    wait_ph(8);
    strobe(8'h55);
    wait_ph(31);
    strobe(8'h81);
    run(40);

    // All-zero mask keeps running with LED off
    wait_ph(5);
    strobe(8'h00);
    run(40);

    // Reset mid-pass with strobe held high
    wait_ph(13);
    bus.STB_I = 1'b1;
    bus.DAT_I = 8'h3C;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb_on = 1'b0;
    chk("midrst_led", 32'(led), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ack", 32'(bus.ACK_O), 32'd0);
    acks = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (bus.ACK_O === 1'b1 || busy === 1'b1) acks++;
    end
    chk("held_strobe_ignored", 32'(acks), 32'd0);
    bus.STB_I = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_after_release", 32'(busy), 32'd0);
    start(8'h3C);
    run(40);
    sb_on = 1'b0;

    // Full-size prescaler: 0x80 gives 512 high, 3584 low per 4096-clock pass
    bus9.STB_I = 1'b1;
    bus9.DAT_I = 8'h80;
    @(posedge clk);
    #1;
    bus9.STB_I = 1'b0;
    chk("p9_busy", 32'(busy9), 32'd1);
    chk("p9_led0", 32'(led9), 32'd1);
    led_bad = 0;
    pass_bad = 0;
    npass = 0;
    for (int i = 1; i <= 8192; i++) begin
      @(posedge clk);
      #1;
      if (led9 !== ((i % 4096) < 512)) led_bad++;
      if (pass9 !== ((i % 4096) == 0)) pass_bad++;
      if (pass9 === 1'b1) npass++;
    end
    chk("p9_led_profile", 32'(led_bad), 32'd0);
    chk("p9_pass_timing", 32'(pass_bad), 32'd0);
    chk("p9_pass_count", 32'(npass), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prewish_blinky.md
Name: prewish_blinky

Overview:
- Wishbone-style slave that sits directly downstream of the mentor that issues 8-bit mask strobes.
- Latches each new 8-bit blink mask and drives one active-high LED.
- Shifts the mask out MSB-first, one bit per prescaler tick, repeating forever.
- Runs on the CLK_O/RST_O pair produced by prewish_controller; the mask-change rate is set at integration time.

Parameters:
- BLINKY_CLK_BITS, default 9: prescaler width. One mask bit lasts 2^BLINKY_CLK_BITS clocks, so one 8-bit pass lasts 8*2^BLINKY_CLK_BITS clocks.

Ports:
- CLK_I, input, 1: system clock. This is the design's only clock.
- RST_I, input, 1: reset, synchronous, active-high.
- STB_I, input, 1: mask strobe from the mentor. Level input; only its rising edge is significant.
- DAT_I, input, 8: mask data, sampled in the cycle the strobe edge is detected.
- ACK_O, output, 1: one-cycle acknowledge of an accepted strobe.
- o_led, output, 1: LED drive, active high.
- o_busy, output, 1: high while in the RUN state.
- o_pass, output, 1: one-cycle pulse at each mask wrap (end of pass).

Behaviour:
- All state updates on the rising edge of CLK_I. No asynchronous logic.
- Reset (RST_I=1 at an edge) sets the following on that edge:
  - state=IDLE
  - o_led=0, ACK_O=0, o_busy=0, o_pass=0
  - mask=0x00, pending_valid=0, pending=0x00
  - bit index=7, prescaler=0
  - stb_prev=1, so a strobe held high across reset release is ignored until it falls and rises again.
- Reset mid-pass discards the active mask and any pending mask.
- Strobe accept:
  - accept = STB_I & ~stb_prev; stb_prev <= STB_I every cycle.
  - A long strobe is accepted exactly once.
  - ACK_O=1 in the cycle after accept, 0 otherwise.
- State IDLE:
  - o_led=0, prescaler held at 0.
  - On accept in cycle N, at edge N+1: mask=DAT_I, idx=7, prescaler=0, state=RUN, o_led=DAT_I[7].
- State RUN:
  - Prescaler increments every cycle and wraps modulo 2^BLINKY_CLK_BITS.
  - tick = (prescaler == all ones).
  - On tick with idx>0: idx=idx-1, o_led=mask[idx-1].
  - On tick with idx==0 (wrap): idx=7, o_pass=1 for one cycle, o_led=next_mask[7].
  - next_mask priority at a wrap:
    1. DAT_I, if accept occurs in this same cycle; pending is also cleared.
    2. Otherwise pending, if pending_valid; pending_valid is cleared.
    3. Otherwise the current mask is kept.
  - Accept without a coincident wrap: pending=DAT_I, pending_valid=1. Last write wins; an overwritten pending mask is lost silently, but ACK_O is still issued for it.
  - The mask never changes mid-pass.
- RUN is left only by reset. Mask 0x00 keeps RUN with LED continuously off.
- o_busy = (state==RUN), registered.
- Latency:
  - Strobe edge to first LED bit from IDLE: 1 cycle.
  - Strobe edge to effect in RUN: up to one full pass.

Test Plan:
All runs use BLINKY_CLK_BITS=2 (4 clocks per bit, 32 per pass) unless noted.

1. Reset, then strobe 0xA8 for 1 cycle -> ACK_O pulses once. o_busy=1 from the next cycle. o_led sequence per 4-clock bit is 1,0,1,0,1,0,0,0 and repeats. o_pass pulses every 32 clocks.
2. While 0xA8 is running, strobe 0xCA mid-pass -> the current pass of 0xA8 completes unchanged. The next pass outputs 1,1,0,0,1,0,1,0. o_pass pulses at the switch.
3. Hold STB_I high for 50 cycles with 0xCA -> exactly one ACK_O and one acceptance. Strobe 0xF0 then 0x0F within the same pass -> 0x0F is displayed next and 0xF0 is never shown.
4. Strobe timed to coincide with a wrap tick (pending 0x55 already queued, coincident data 0x81) -> next pass shows 0x81 and 0x55 is discarded.
5. Assert RST_I for 1 cycle mid-pass with STB_I held high -> o_led=0, o_busy=0, ACK_O=0 after the edge. No acceptance until STB_I falls and rises again.
6. BLINKY_CLK_BITS=9 with mask 0x80 -> o_led high for 512 clocks, then low for 3584. o_pass period is 4096 clocks.
